// File: rtl/simple_uart.sv
// -----------------------------------------------------------------------------
// simple_uart
// Minimal 8N1 UART peripheral for the processor peripheral bus.
//   - 32-bit baud divider register (byte-lane writable); one bit-time is
//     divider+2 clock cycles.
//   - One transmit shift register; data writes stall via reg_dat_wait while
//     a frame (or the post-divider-change idle period) is in flight.
//   - One-byte receive buffer; reads return the byte or an "empty" code.
//
// Ports
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset
//   ser_tx        serial transmit line (idle high)
//   ser_rx        serial receive line (idle high)
//   reg_div_we    per-byte write enables for the divider
//   reg_div_di    divider write data
//   reg_div_do    current divider value
//   reg_dat_we    transmit request, reg_dat_di[7:0] is sent
//   reg_dat_re    read strobe, consumes the receive buffer
//   reg_dat_di    transmit data (bits [7:0] used)
//   reg_dat_do    received byte {24'b0, byte} or empty code
//   reg_dat_wait  stall for reg_dat_we while the transmitter is busy
//
// Build option
//   SIMPLE_UART_EMPTY_ONES_EN  defined   : empty code is 32'hFFFFFFFF
//                              undefined : empty code is 32'h00000000
// -----------------------------------------------------------------------------
module simple_uart (
   input  logic        clk,
   input  logic        resetn,
   output logic        ser_tx,
   input  logic        ser_rx,
   input  logic [3:0]  reg_div_we,
   input  logic [31:0] reg_div_di,
   output logic [31:0] reg_div_do,
   input  logic        reg_dat_we,
   input  logic        reg_dat_re,
   input  logic [31:0] reg_dat_di,
   output logic [31:0] reg_dat_do,
   output logic        reg_dat_wait
);

`ifdef SIMPLE_UART_EMPTY_ONES_EN
   localparam logic [31:0] EMPTY_CODE = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] EMPTY_CODE = 32'h0000_0000;
`endif

   // Receiver sequence: idle, start-bit centring, eight data bits, stop bit.
   typedef enum logic [3:0] {
      RX_IDLE  = 4'd0,
      RX_START = 4'd1,
      RX_BIT0  = 4'd2,
      RX_BIT1  = 4'd3,
      RX_BIT2  = 4'd4,
      RX_BIT3  = 4'd5,
      RX_BIT4  = 4'd6,
      RX_BIT5  = 4'd7,
      RX_BIT6  = 4'd8,
      RX_BIT7  = 4'd9,
      RX_STOP  = 4'd10
   } rx_state_t;

   logic [31:0] div_value;

   logic [9:0]  tx_pattern_reg;
   logic [3:0]  tx_bitcnt_reg;
   logic [31:0] tx_divcnt_reg;
   logic        tx_dummy_reg;

   rx_state_t   rx_state_reg;
   logic [31:0] rx_divcnt_reg;
   logic [7:0]  rx_pattern_reg;
   logic [7:0]  rx_data_reg;
   logic        rx_valid_reg;

   // Only the low byte of the transmit data is ever sent.
   logic unused_dat_di_bits;
   assign unused_dat_di_bits = &{1'b0, reg_dat_di[31:8]};

   // ---------------------------------------------------------------------
   // Divider register: four independent byte lanes, reset value 1.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_div_lane
         logic [7:0] lane_reg;
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               lane_reg <= (gi == 0) ? 8'h01 : 8'h00;
            end else if (reg_div_we[gi]) begin
               lane_reg <= reg_div_di[8*gi +: 8];
            end
         end
         assign div_value[8*gi +: 8] = lane_reg;
      end
   endgenerate

   assign reg_div_do = div_value;

   // ---------------------------------------------------------------------
   // Transmitter
   // ---------------------------------------------------------------------
   assign ser_tx       = tx_pattern_reg[0];
   assign reg_dat_wait = reg_dat_we && ((tx_bitcnt_reg != 4'd0) || tx_dummy_reg);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_pattern_reg <= 10'h3FF;
         tx_bitcnt_reg  <= 4'd0;
         tx_divcnt_reg  <= 32'd0;
         tx_dummy_reg   <= 1'b1;
      end else begin
         tx_divcnt_reg <= tx_divcnt_reg + 32'd1;
         if (tx_dummy_reg && (tx_bitcnt_reg == 4'd0)) begin
            // 15 idle bit-times so the far end can resync to a new rate.
            tx_pattern_reg <= 10'h3FF;
            tx_bitcnt_reg  <= 4'd15;
            tx_divcnt_reg  <= 32'd0;
            tx_dummy_reg   <= 1'b0;
         end else if (reg_dat_we && (tx_bitcnt_reg == 4'd0)) begin
            tx_pattern_reg <= {1'b1, reg_dat_di[7:0], 1'b0};
            tx_bitcnt_reg  <= 4'd10;
            tx_divcnt_reg  <= 32'd0;
         end else if ((tx_divcnt_reg > div_value) && (tx_bitcnt_reg != 4'd0)) begin
            tx_pattern_reg <= {1'b1, tx_pattern_reg[9:1]};
            tx_bitcnt_reg  <= tx_bitcnt_reg - 4'd1;
            tx_divcnt_reg  <= 32'd0;
         end
         // A divider write always re-arms the idle period, even if the
         // branch above just consumed the previous request.
         if (|reg_div_we) begin
            tx_dummy_reg <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Receiver
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_state_reg   <= RX_IDLE;
         rx_divcnt_reg  <= 32'd0;
         rx_pattern_reg <= 8'd0;
         rx_data_reg    <= 8'd0;
         rx_valid_reg   <= 1'b0;
      end else begin
         rx_divcnt_reg <= rx_divcnt_reg + 32'd1;
         // A completing byte below overrides this clear.
         if (reg_dat_re) begin
            rx_valid_reg <= 1'b0;
         end
         case (rx_state_reg)
            RX_IDLE: begin
               rx_divcnt_reg <= 32'd0;
               if (!ser_rx) begin
                  rx_state_reg <= RX_START;
               end
            end
            RX_START: begin
               // Half a bit-time into the start bit; 33-bit compare.
               if ({rx_divcnt_reg, 1'b0} > {1'b0, div_value}) begin
                  rx_state_reg  <= RX_BIT0;
                  rx_divcnt_reg <= 32'd0;
               end
            end
            RX_STOP: begin
               if (rx_divcnt_reg > div_value) begin
                  rx_data_reg   <= rx_pattern_reg;
                  rx_valid_reg  <= 1'b1;
                  rx_state_reg  <= RX_IDLE;
                  rx_divcnt_reg <= 32'd0;
               end
            end
            default: begin
               // Data bits arrive LSB first, so shift in from the top.
               if (rx_divcnt_reg > div_value) begin
                  rx_pattern_reg <= {ser_rx, rx_pattern_reg[7:1]};
                  rx_state_reg   <= rx_state_t'(rx_state_reg + 4'd1);
                  rx_divcnt_reg  <= 32'd0;
               end
            end
         endcase
      end
   end

   assign reg_dat_do = rx_valid_reg ? {24'h0, rx_data_reg} : EMPTY_CODE;

endmodule

// File: tb/tb_simple_uart.sv
// -----------------------------------------------------------------------------
// tb_simple_uart
// Self-checking bench for simple_uart. Expected serial waveforms and register
// values are derived from the 8N1 framing rules and the divider+2 bit-time.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_simple_uart;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ser_tx;
   logic        ser_rx;
   logic [3:0]  reg_div_we;
   logic [31:0] reg_div_di;
   logic [31:0] reg_div_do;
   logic        reg_dat_we;
   logic        reg_dat_re;
   logic [31:0] reg_dat_di;
   logic [31:0] reg_dat_do;
   logic        reg_dat_wait;

   int total = 0;
   int bad   = 0;
   logic [31:0] mdl_div;

`ifdef SIMPLE_UART_EMPTY_ONES_EN
   localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] EMPTY = 32'h0000_0000;
`endif

   always #5 clk = ~clk;

   simple_uart dut (
      .clk          (clk),
      .resetn       (resetn),
      .ser_tx       (ser_tx),
      .ser_rx       (ser_rx),
      .reg_div_we   (reg_div_we),
      .reg_div_di   (reg_div_di),
      .reg_div_do   (reg_div_do),
      .reg_dat_we   (reg_dat_we),
      .reg_dat_re   (reg_dat_re),
      .reg_dat_di   (reg_dat_di),
      .reg_dat_do   (reg_dat_do),
      .reg_dat_wait (reg_dat_wait)
   );

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, required finish before 5ms");
      $fatal(1);
   end

   // Divider write; the model applies each enabled byte lane.
   task automatic write_div(input logic [3:0] we, input logic [31:0] di);
      @(negedge clk);
      reg_div_we = we;
      reg_div_di = di;
      @(negedge clk);
      reg_div_we = 4'd0;
      for (int l = 0; l < 4; l++)
         if (we[l]) mdl_div[8*l +: 8] = di[8*l +: 8];
   endtask

   // Request a transmit; returns the number of cycles it was stalled.
   task automatic drive_write(input logic [7:0] d, output int waits);
      @(negedge clk);
      reg_dat_di      = $urandom();
      reg_dat_di[7:0] = d;
      reg_dat_we      = 1'b1;
      #1;
      waits = 0;
      while (reg_dat_wait !== 1'b0 && waits < 4000) begin
         waits++;
         @(negedge clk);
         #1;
      end
      if (waits >= 4000) begin
         total++; bad++;
         $display("FAIL write_timeout: stalled %0d cycles, required accept", waits);
      end
      @(posedge clk);
      #1;
      reg_dat_we = 1'b0;
   endtask

   // Check one 8N1 frame on ser_tx, starting at the negedge after acceptance.
   task automatic check_frame(input logic [7:0] d, input string name);
      int   bt;
      logic exp_bit;
      int   errs;
      logic seen;
      bt = int'(mdl_div) + 2;
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      exp_bit = 1'b0;
         else if (k == 9) exp_bit = 1'b1;
         else             exp_bit = d[k-1];
         errs = 0;
         seen = exp_bit;
         for (int c = 0; c < bt; c++) begin
            @(negedge clk);
            if (ser_tx !== exp_bit) begin
               errs++;
               seen = ser_tx;
            end
         end
         total++;
         if (errs != 0) begin
            bad++;
            $display("FAIL %s bit%0d: ser_tx=%b (%0d bad samples), required %b", name, k, seen, errs, exp_bit);
         end
      end
      $display("tx frame %s byte=%02h div=%0d checked", name, d, mdl_div);
   endtask

   // Drive one 8N1 frame on ser_rx at the model bit-time.
   task automatic drive_rx(input logic [7:0] d);
      int bt;
      bt = int'(mdl_div) + 2;
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      ser_rx = 1'b0;
         else if (k == 9) ser_rx = 1'b1;
         else             ser_rx = d[k-1];
         repeat (bt) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      resetn     = 1'b0;
      ser_rx     = 1'b1;
      reg_div_we = 4'd0;
      reg_div_di = 32'd0;
      reg_dat_we = 1'b1;
      reg_dat_re = 1'b0;
      reg_dat_di = 32'd0;
      repeat (3) @(negedge clk);
      mdl_div = 32'd1;
      total++;
      if (ser_tx !== 1'b1) begin bad++; $display("FAIL reset_ser_tx: got %b, required 1", ser_tx); end
      total++;
      if (reg_div_do !== mdl_div) begin bad++; $display("FAIL reset_div: got %h, required %h", reg_div_do, mdl_div); end
      total++;
      if (reg_dat_do !== EMPTY) begin bad++; $display("FAIL reset_dat: got %h, required %h", reg_dat_do, EMPTY); end
      // Idle period pending after reset, so a write request must stall.
      total++;
      if (reg_dat_wait !== 1'b1) begin bad++; $display("FAIL reset_wait: got %b, required 1", reg_dat_wait); end
      reg_dat_we = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      $display("reset checked");
   endtask

   task automatic test_divider();
      int   w;
      int   hi_bad;
      logic [7:0] d;
      write_div(4'b0101, 32'h1234_5678);
      total++;
      if (reg_div_do !== 32'h0034_0078 || reg_div_do !== mdl_div)
         begin bad++; $display("FAIL div_lanes: got %h, required 00340078", reg_div_do); end
      write_div(4'b1111, 32'd4);
      total++;
      if (reg_div_do !== 32'd4) begin bad++; $display("FAIL div_full: got %h, required 00000004", reg_div_do); end
      d = 8'($urandom());
      hi_bad = 0;
      fork
         begin
            for (int c = 0; c < 15 * (int'(mdl_div) + 2); c++) begin
               @(negedge clk);
               if (ser_tx !== 1'b1) hi_bad++;
            end
         end
         drive_write(d, w);
      join
      total++;
      if (hi_bad != 0) begin bad++; $display("FAIL div_idle: %0d low samples, required 0", hi_bad); end
      total++;
      if (w < 15 * (int'(mdl_div) + 2))
         begin bad++; $display("FAIL div_idle_stall: stalled %0d, required >= %0d", w, 15 * (int'(mdl_div) + 2)); end
      check_frame(d, "after_div");
   endtask

   task automatic test_tx_random();
      int w;
      logic [7:0] d;
      for (int i = 0; i < 3; i++) begin
         write_div(4'b1111, 32'($urandom_range(5, 2)));
         d = 8'($urandom());
         drive_write(d, w);
         check_frame(d, "random");
      end
      write_div(4'b1111, 32'd4);
      drive_write(8'hA5, w);
      check_frame(8'hA5, "A5");
   endtask

   task automatic test_back_to_back();
      int w0, w1;
      logic [7:0] a, b;
      a = 8'($urandom());
      b = 8'($urandom());
      drive_write(a, w0);
      total++;
      if (w0 != 0) begin bad++; $display("FAIL b2b_idle_accept: stalled %0d, required 0", w0); end
      fork
         begin
            check_frame(a, "b2b_first");
            @(negedge clk);
            total++;
            if (ser_tx !== 1'b1) begin bad++; $display("FAIL b2b_stop_tail: got %b, required 1", ser_tx); end
            check_frame(b, "b2b_second");
         end
         drive_write(b, w1);
      join
      total++;
      if (w1 != 10 * (int'(mdl_div) + 2))
         begin bad++; $display("FAIL b2b_stall: stalled %0d, required %0d", w1, 10 * (int'(mdl_div) + 2)); end
   endtask

   task automatic test_reset_midframe();
      int w;
      logic [7:0] d, d2;
      d      = 8'($urandom());
      d[3]   = 1'b0;          // frame bit 4 carries data bit 3
      d2     = 8'($urandom());
      drive_write(d, w);
      repeat (4 * (int'(mdl_div) + 2) + 2) @(negedge clk);
      total++;
      if (ser_tx !== 1'b0) begin bad++; $display("FAIL midframe_bit4: got %b, required 0", ser_tx); end
      #2;
      resetn = 1'b0;
      #1;
      mdl_div = 32'd1;
      total++;
      if (ser_tx !== 1'b1) begin bad++; $display("FAIL midframe_async: got %b, required 1", ser_tx); end
      total++;
      if (reg_div_do !== mdl_div) begin bad++; $display("FAIL midframe_div: got %h, required %h", reg_div_do, mdl_div); end
      @(negedge clk);
      resetn          = 1'b1;
      reg_dat_di      = $urandom();
      reg_dat_di[7:0] = d2;
      reg_dat_we      = 1'b1;
      #1;
      w = 0;
      while (reg_dat_wait !== 1'b0 && w < 4000) begin
         w++;
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      reg_dat_we = 1'b0;
      total++;
      if (w != 1 + 15 * (int'(mdl_div) + 2))
         begin bad++; $display("FAIL midframe_dummy_stall: stalled %0d, required %0d", w, 1 + 15 * (int'(mdl_div) + 2)); end
      check_frame(d2, "post_reset");
   endtask

   task automatic test_rx();
      logic [7:0] d, e;
      write_div(4'b1111, 32'd4);
      drive_rx(8'h3C);
      #1;
      total++;
      if (reg_dat_do !== 32'h0000_003C) begin bad++; $display("FAIL rx_3c: got %h, required 0000003c", reg_dat_do); end
      $display("rx byte 3c div=4 read %h", reg_dat_do);
      @(negedge clk);
      reg_dat_re = 1'b1;
      @(negedge clk);
      reg_dat_re = 1'b0;
      total++;
      if (reg_dat_do !== EMPTY) begin bad++; $display("FAIL rx_consume: got %h, required %h", reg_dat_do, EMPTY); end
      for (int i = 0; i < 4; i++) begin
         write_div(4'b1111, 32'($urandom_range(7, 2)));
         d = 8'($urandom());
         drive_rx(d);
         #1;
         total++;
         if (reg_dat_do !== {24'h0, d}) begin bad++; $display("FAIL rx_random: got %h, required %h", reg_dat_do, {24'h0, d}); end
         $display("rx byte %02h div=%0d read %h", d, mdl_div, reg_dat_do);
      end
      // Unread byte is overwritten by the next one.
      d = 8'($urandom());
      e = 8'($urandom());
      drive_rx(d);
      drive_rx(e);
      #1;
      total++;
      if (reg_dat_do !== {24'h0, e}) begin bad++; $display("FAIL rx_overwrite: got %h, required %h", reg_dat_do, {24'h0, e}); end
   endtask

   task automatic test_rx_race();
      int   n;
      logic got;
      write_div(4'b1111, 32'd4);
      got = 1'b0;
      n   = 0;
      fork
         drive_rx(8'h81);
         begin
            @(negedge clk);
            reg_dat_re = 1'b1;
            while (!got && n < 1000) begin
               @(negedge clk);
               n++;
               if (reg_dat_do !== EMPTY) got = 1'b1;
            end
            reg_dat_re = 1'b0;
         end
      join
      total++;
      if (!got) begin bad++; $display("FAIL race_valid: got %h, required 00000081", reg_dat_do); end
      repeat (2) @(negedge clk);
      total++;
      if (reg_dat_do !== 32'h0000_0081) begin bad++; $display("FAIL race_data: got %h, required 00000081", reg_dat_do); end
      $display("rx race byte 81 read %h", reg_dat_do);
   endtask

   initial begin
      test_reset();
      test_divider();
      test_tx_random();
      test_back_to_back();
      test_reset_midframe();
      test_rx();
      test_rx_race();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
